// File: rtl/heart_hit_detector_pkg.sv
// Shared definitions for the heart hit detector and its neighbouring sprite stages.
// Holds the damage FSM states, the 640x480 screen limits and the HP defaults.
package heart_hit_detector_pkg;

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      DEAD   = 2'd2
   } hit_state_t;

   localparam int XY_W          = 10;
   localparam int SCREEN_LAST_X = 639;
   localparam int SCREEN_LAST_Y = 479;

   localparam int HP_MAX_DEF  = 20;
   localparam int DAMAGE_DEF  = 3;
   localparam int IFRAMES_DEF = 30;

endpackage

// File: rtl/heart_hit_detector_frame_end_strobe.sv
// One-cycle frame-end strobe, delayed one pixel so it lines up with registered
// sprite on-flags. Also usable by the sprite movement logic.
module heart_hit_detector_frame_end_strobe
   import heart_hit_detector_pkg::*;
#(
   parameter int LAST_X = SCREEN_LAST_X,
   parameter int LAST_Y = SCREEN_LAST_Y
)(
   input  logic            Pclk,
   input  logic            rst_n,
   input  logic [XY_W-1:0] xx,
   input  logic [XY_W-1:0] yy,
   output logic            fe_p1
);

   always_ff @(posedge Pclk or negedge rst_n) begin
      if (!rst_n) begin
         fe_p1 <= 1'b0;
      end else begin
         fe_p1 <= (xx == XY_W'(LAST_X)) && (yy == XY_W'(LAST_Y));
      end
   end

endmodule

// File: rtl/heart_hit_detector.sv
// Bullet/heart overlap detector: latches overlap per frame, applies damage at frame
// end, runs the invulnerability window and raises a sticky game-over flag.
module heart_hit_detector
   import heart_hit_detector_pkg::*;
#(
   parameter int HP_MAX  = HP_MAX_DEF,
   parameter int DAMAGE  = DAMAGE_DEF,
   parameter int IFRAMES = IFRAMES_DEF,
   parameter int HP_W    = 5,
   parameter int LAST_X  = SCREEN_LAST_X,
   parameter int LAST_Y  = SCREEN_LAST_Y
)(
   input  logic            Pclk,
   input  logic            rst_n,
   input  logic [XY_W-1:0] xx,
   input  logic [XY_W-1:0] yy,
   input  logic            aactive,
   input  logic            BulletSpriteOn,
   input  logic            HeartSpriteOn,
   input  logic            enable,
   input  logic            hp_restart,
   output logic [HP_W-1:0] hp,
   output logic            hit_pulse,
   output logic            invuln,
   output logic            heart_blink,
   output logic            game_over
);

   localparam int CNT_W = (IFRAMES > 1) ? $clog2(IFRAMES) : 1;
   localparam logic signed [HP_W+1:0] DMG_S = (HP_W+2)'(DAMAGE);

   function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] v);
      logic signed [HP_W+1:0] d;
      d = $signed({2'b00, v}) - DMG_S;
      return (d <= 0) ? '0 : d[HP_W-1:0];
   endfunction

   hit_state_t       state, state_n;
   logic [HP_W-1:0]  hp_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       fcnt, fcnt_n;
   logic             invuln_n, go_n, hit_n, blink_n;
   logic             act_p1, fe_p1, ov_p1, ov_lat, hit_p1;

   heart_hit_detector_frame_end_strobe #(
      .LAST_X (LAST_X),
      .LAST_Y (LAST_Y)
   ) u_fe (
      .Pclk  (Pclk),
      .rst_n (rst_n),
      .xx    (xx),
      .yy    (yy),
      .fe_p1 (fe_p1)
   );

   // p1: pixel-aligned with the registered sprite flags
   assign ov_p1  = act_p1 & BulletSpriteOn & HeartSpriteOn & enable;
   assign hit_p1 = ov_lat | ov_p1;

   always_comb begin
      state_n  = state;
      hp_n     = hp;
      cnt_n    = cnt;
      invuln_n = invuln;
      go_n     = game_over;
      hit_n    = 1'b0;
      fcnt_n   = fe_p1 ? fcnt + 3'd1 : fcnt;
      if (hp_restart) begin
         state_n  = ALIVE;
         hp_n     = HP_W'(HP_MAX);
         cnt_n    = '0;
         invuln_n = 1'b0;
         go_n     = 1'b0;
      end else if (fe_p1) begin
         unique case (state)
            ALIVE: begin
               if (hit_p1) begin
                  hp_n  = sat_sub(hp);
                  hit_n = 1'b1;
                  if (hp_n == '0) begin
                     state_n = DEAD;
                     go_n    = 1'b1;
                  end else begin
                     state_n  = INVULN;
                     invuln_n = 1'b1;
                     cnt_n    = CNT_W'(IFRAMES - 1);
                  end
               end
            end
            INVULN: begin
               if (cnt == '0) begin
                  state_n  = ALIVE;
                  invuln_n = 1'b0;
               end else begin
                  cnt_n = cnt - CNT_W'(1);
               end
            end
            DEAD:    state_n = DEAD;
            default: state_n = ALIVE;
         endcase
      end
      // Blink follows the next-state values so it never outlives the i-frame window
      blink_n = invuln_n & fcnt_n[2];
   end

   // p2: frame-end results, visible the cycle after the strobe
   always_ff @(posedge Pclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ALIVE;
         hp          <= HP_W'(HP_MAX);
         cnt         <= '0;
         fcnt        <= '0;
         invuln      <= 1'b0;
         game_over   <= 1'b0;
         hit_pulse   <= 1'b0;
         heart_blink <= 1'b0;
         ov_lat      <= 1'b0;
         act_p1      <= 1'b0;
      end else begin
         state       <= state_n;
         hp          <= hp_n;
         cnt         <= cnt_n;
         fcnt        <= fcnt_n;
         invuln      <= invuln_n;
         game_over   <= go_n;
         hit_pulse   <= hit_n;
         heart_blink <= blink_n;
         ov_lat      <= (hp_restart || fe_p1) ? 1'b0 : (ov_lat | ov_p1);
         act_p1      <= aactive;
      end
   end

endmodule

// File: tb/tb_heart_hit_detector.sv
// Scoreboard bench for heart_hit_detector: compressed frames ending at (639,479),
// a frame-level reference model and a monitor checking results after each frame end.
`timescale 1ns/1ps
module tb_heart_hit_detector;
   import heart_hit_detector_pkg::*;

   localparam int HP_MAX  = 20;
   localparam int DAMAGE  = 3;
   localparam int IFRAMES = 30;
   localparam int HP_W    = 5;
   localparam int NPIX    = 18;   // 0..14 random active, 15 = last pixel, 16..17 blanking

   logic            Pclk = 1'b0;
   logic            rst_n = 1'b0;
   logic [9:0]      xx = '0, yy = '0;
   logic            aactive = 1'b0, BulletSpriteOn = 1'b0, HeartSpriteOn = 1'b0;
   logic            enable = 1'b0, hp_restart = 1'b0;
   logic [HP_W-1:0] hp;
   logic            hit_pulse, invuln, heart_blink, game_over;

   heart_hit_detector #(
      .HP_MAX(HP_MAX), .DAMAGE(DAMAGE), .IFRAMES(IFRAMES), .HP_W(HP_W),
      .LAST_X(639), .LAST_Y(479)
   ) dut (
      .Pclk(Pclk), .rst_n(rst_n), .xx(xx), .yy(yy), .aactive(aactive),
      .BulletSpriteOn(BulletSpriteOn), .HeartSpriteOn(HeartSpriteOn),
      .enable(enable), .hp_restart(hp_restart),
      .hp(hp), .hit_pulse(hit_pulse), .invuln(invuln),
      .heart_blink(heart_blink), .game_over(game_over)
   );

   always #5 Pclk = ~Pclk;

   typedef struct {
      int hp;
      bit hit;
      bit inv;
      bit blink;
      bit go;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   frame_no = 0;

   // frame-level model state
   int m_hp, m_protect, m_fcnt;
   bit m_dead;

   logic prev_b = 1'b0, prev_h = 1'b0;
   logic fe1 = 1'b0, fe2 = 1'b0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s (frame %0d): got %0d, expected %0d", name, frame_no, got, want);
      end
   endtask

   task automatic model_reset();
      m_hp = HP_MAX; m_protect = 0; m_dead = 0; m_fcnt = 0;
   endtask

   // m_protect = number of further frame ends that stay invulnerable
   task automatic model_frame_end(input bit ov, input bit restart);
      exp_t e;
      e.hit = 0;
      if (restart) begin
         m_hp = HP_MAX; m_protect = 0; m_dead = 0;
      end else if (!m_dead) begin
         if (m_protect > 0) begin
            m_protect--;
         end else if (ov) begin
            e.hit = 1;
            m_hp  = (m_hp > DAMAGE) ? m_hp - DAMAGE : 0;
            if (m_hp == 0) m_dead = 1;
            else m_protect = IFRAMES;
         end
      end
      m_fcnt  = (m_fcnt + 1) % 8;
      e.hp    = m_hp;
      e.inv   = (m_protect > 0);
      e.blink = e.inv && (m_fcnt >= 4);
      e.go    = m_dead;
      sb_q.push_back(e);
   endtask

   always @(posedge Pclk) begin
      fe1 <= (xx == 10'd639) && (yy == 10'd479);
      fe2 <= fe1;
   end

   // Monitor: results due the cycle after the delayed frame end; hit_pulse nowhere else
   always @(negedge Pclk) begin
      if (rst_n) begin
         if (fe2) begin
            if (sb_q.size() == 0) begin
               chk("frame_end_without_expectation", 1, 0);
            end else begin : pop
               exp_t e;
               e = sb_q.pop_front();
               chk("hp", int'(hp), e.hp);
               chk("hit_pulse", int'(hit_pulse), int'(e.hit));
               chk("invuln", int'(invuln), int'(e.inv));
               chk("heart_blink", int'(heart_blink), int'(e.blink));
               chk("game_over", int'(game_over), int'(e.go));
               frame_no++;
            end
         end else begin
            chk("hit_pulse_outside_frame_end", int'(hit_pulse), 0);
         end
      end
   end

   // mode: 0 no overlap, 1 overlap at (100,100), 2 overlap only at last pixel, 3 random
   task automatic run_frame(input int mode, input bit en, input bit restart, input int rst_at);
      logic [9:0] px[NPIX];
      logic [9:0] py[NPIX];
      bit pa[NPIX], pb[NPIX], ph[NPIX];
      bit ov;
      int lo;
      for (int i = 0; i < NPIX; i++) begin
         if (i < 15) begin
            px[i] = 10'($urandom_range(638)); py[i] = 10'($urandom_range(478)); pa[i] = 1;
         end else if (i == 15) begin
            px[i] = 10'd639; py[i] = 10'd479; pa[i] = 1;
         end else begin
            px[i] = 10'($urandom_range(799)); py[i] = 10'($urandom_range(524, 480)); pa[i] = 0;
         end
         pb[i] = 1'($urandom_range(1));
         ph[i] = 1'($urandom_range(1));
         if (pa[i]) begin
            if (mode == 3) begin
               if (pb[i] && ph[i] && $urandom_range(7) != 0) ph[i] = 0;
            end else if ((mode == 1 && i == 7) || (mode == 2 && i == 15)) begin
               pb[i] = 1; ph[i] = 1;
               if (mode == 1) begin px[i] = 10'd100; py[i] = 10'd100; end
            end else if (pb[i]) begin
               ph[i] = 0;
            end
         end
      end
      // a mid-frame reset also clears the aligned active flag, so only later pixels count
      lo = (rst_at >= 0) ? rst_at : 0;
      ov = 0;
      for (int i = lo; i < NPIX; i++) if (pa[i] && pb[i] && ph[i]) ov = en;
      for (int i = 0; i < NPIX; i++) begin
         @(posedge Pclk);
         #1;
         xx = px[i]; yy = py[i]; aactive = pa[i];
         BulletSpriteOn = prev_b; HeartSpriteOn = prev_h;
         enable = en;
         hp_restart = restart && (i == 16);
         prev_b = pb[i]; prev_h = ph[i];
         if (i == 16) model_frame_end(ov, restart);
         if (i == rst_at) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
            model_reset();
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d frames checked", frame_no);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge Pclk);
      #2;
      chk("reset_hp", int'(hp), HP_MAX);
      chk("reset_hit_pulse", int'(hit_pulse), 0);
      chk("reset_invuln", int'(invuln), 0);
      chk("reset_heart_blink", int'(heart_blink), 0);
      chk("reset_game_over", int'(game_over), 0);
      @(posedge Pclk);
      #1 rst_n = 1'b1;

      repeat (3) run_frame(0, 1, 0, -1);
      run_frame(1, 1, 0, -1);
      repeat (34) run_frame(0, 1, 0, -1);

      run_frame(0, 1, 1, -1);
      repeat (40) run_frame(1, 1, 0, -1);

      run_frame(0, 1, 1, -1);
      run_frame(2, 1, 0, -1);
      run_frame(0, 1, 0, -1);

      run_frame(0, 1, 1, -1);
      for (int k = 0; k < 300 && !m_dead; k++) run_frame(1, 1, 0, -1);
      chk("model_reached_dead", int'(m_dead), 1);
      repeat (3) run_frame(1, 1, 0, -1);

      run_frame(1, 1, 1, -1);
      run_frame(1, 1, 0, -1);
      run_frame(1, 1, 1, -1);
      run_frame(1, 1, 0, 10);
      run_frame(1, 0, 0, -1);

      for (int k = 0; k < 80; k++)
         run_frame(int'($urandom_range(3)), ($urandom_range(3) != 0),
                   ($urandom_range(9) == 0), -1);

      repeat (4) @(posedge Pclk);
      #2;
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
